// File: rtl/controle_registrador_pkg.sv
// controle_registrador_pkg
//   Shared encodings for the register sequencer: command opcodes, register
//   function codes driven onto func, FSM state encodings and the datapath
//   width of the register it steers (registradorX).
//   Helpers:
//     eff_count  - number of EXEC cycles a command needs (shifts saturate at 4)
//     op_to_func - command opcode to register function code
package controle_registrador_pkg;

    localparam int REG_W = 4;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SHIFTR = 2'b01;
    localparam logic [1:0] OP_SHIFTL = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [2:0] FUNC_HOLD   = 3'b000;
    localparam logic [2:0] FUNC_LOAD   = 3'b001;
    localparam logic [2:0] FUNC_SHIFTR = 3'b010;
    localparam logic [2:0] FUNC_SHIFTL = 3'b011;
    localparam logic [2:0] FUNC_RESET  = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;

    localparam logic [2:0] MAX_SHIFT = 3'd4;

    function automatic logic [2:0] eff_count(input logic [1:0] op_v,
                                             input logic [2:0] amount_v);
        logic [2:0] n;
        if (op_v == OP_LOAD || op_v == OP_CLEAR) begin
            n = 3'd1;
        end else if (amount_v > MAX_SHIFT) begin
            n = MAX_SHIFT;
        end else begin
            n = amount_v;
        end
        return n;
    endfunction

    function automatic logic [2:0] op_to_func(input logic [1:0] op_v);
        logic [2:0] f;
        case (op_v)
            OP_LOAD:   f = FUNC_LOAD;
            OP_SHIFTR: f = FUNC_SHIFTR;
            OP_SHIFTL: f = FUNC_SHIFTL;
            default:   f = FUNC_RESET;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/registradorX.sv
// registradorX
//   REG_W-bit register steered by a function code. It has no reset of its
//   own: contents survive a sequencer reset, so an aborted command leaves
//   whatever shifts had already been applied.
//   Ports:
//     clock - rising-edge clock
//     func  - HOLD / LOAD / SHIFTR / SHIFTL / RESET (clear to zero)
//     inX   - parallel load data
//     outX  - register contents
module registradorX
    import controle_registrador_pkg::*;
(
    input  logic             clock,
    input  logic [2:0]       func,
    input  logic [REG_W-1:0] inX,
    output logic [REG_W-1:0] outX
);

    logic [REG_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        case (func)
            FUNC_LOAD:   data_d = inX;
            FUNC_SHIFTR: data_d = {1'b0, data_q[REG_W-1:1]};
            FUNC_SHIFTL: data_d = {data_q[REG_W-2:0], 1'b0};
            FUNC_RESET:  data_d = '0;
            default:     data_d = data_q;
        endcase
    end

    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

    assign outX = data_q;

endmodule

// File: rtl/controle_registrador.sv
// controle_registrador
//   Command sequencer for registradorX. A start in IDLE latches the opcode
//   and an effective cycle count; func then carries the opcode's function
//   code for that many cycles, followed by a single done cycle.
//   Ports:
//     clock  - rising-edge clock
//     reset  - synchronous active-high reset, wins over start
//     start  - command request, only honoured in IDLE
//     op     - 00 LOAD, 01 SHIFTR, 10 SHIFTL, 11 CLEAR
//     amount - shift count, saturates at 4, ignored for LOAD/CLEAR
//     func   - registered register function code
//     busy   - registered, high from the cycle after start through done
//     done   - registered one-cycle completion pulse
//
//   state | meaning
//   IDLE  | waiting for start, func=HOLD
//   EXEC  | driving func with the latched op for cnt cycles
//   FIN   | done pulse, func=HOLD, returns to IDLE
module controle_registrador
    import controle_registrador_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] amount,
    output logic [2:0] func,
    output logic       busy,
    output logic       done
);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [2:0] func_q, func_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    cnt_d   = eff_count(op, amount);
                    state_d = (cnt_d == 3'd0) ? ST_FIN : ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Terminal count at 1 so the counter never passes through 0.
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are a registered decode of the next state.
        func_d = (state_d == ST_EXEC) ? op_to_func(op_d) : FUNC_HOLD;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            op_q    <= OP_LOAD;
            func_q  <= FUNC_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            func_q  <= func_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign func = func_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/controle_registrador.md
CONTROLE_REGISTRADOR -- requirements
Module: controle_registrador

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock `clock`, reset `reset`.
REQ-002 Port `clock`: input, 1 bit, rising-edge clock for all state.
REQ-003 Port `reset`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `start`: input, 1 bit, command request, sampled on rising edge.
REQ-005 Port `op`: input, 2 bits, command: 00 LOAD, 01 SHIFTR, 10 SHIFTL, 11 CLEAR.
REQ-006 Port `amount`: input, 3 bits, shift count for SHIFTR/SHIFTL, ignored otherwise.
REQ-007 Port `func`: output, 3 bits, registered register-function code: HOLD 000, LOAD 001, SHIFTR 010, SHIFTL 011, RESET 100.
REQ-008 Port `busy`: output, 1 bit, high while a command is in progress.
REQ-009 Port `done`: output, 1 bit, one-cycle completion pulse.

Function
REQ-010 FSM states SHALL be IDLE, EXEC and FIN, and all outputs SHALL be registered.
REQ-011 IDLE: func=HOLD, busy=0, done=0.
REQ-012 In IDLE, on an edge with start=1, the block SHALL latch op and an effective count, and busy SHALL rise in the next cycle.
REQ-013 Effective count SHALL be 1 for LOAD and CLEAR, and min(amount,4) for shifts; amount values 5..7 SHALL saturate to 4.
REQ-014 For count N≥1: state EXEC, with func equal to the op's code (CLEAR→RESET 100) for exactly N consecutive cycles, starting the cycle after start was sampled.
REQ-015 For count 0: no EXEC cycles; the block SHALL go straight to FIN; func SHALL stay HOLD throughout.
REQ-016 FIN: func=HOLD, busy=1, done=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-017 Latency from the start-sampling edge to the done cycle SHALL be N+1 cycles (1 cycle for N=0).
REQ-018 start asserted while busy=1 (EXEC or FIN) SHALL be ignored and not queued; op and amount changes while busy SHALL have no effect.
REQ-019 The internal down-counter SHALL be 3 bits and SHALL never wrap: EXEC SHALL exit when the count reaches its last cycle.
REQ-020 func SHALL never take the values 101..111.

Reset
REQ-021 On an edge with reset=1 the block SHALL enter IDLE and set func=HOLD, busy=0, done=0 and the counter to 0, regardless of state.
REQ-022 Reset during EXEC SHALL abort the command: func=HOLD from the next cycle, with no done pulse.
REQ-023 Reset SHALL take priority over a simultaneous start.

Structure
REQ-024 Function codes (HOLD/LOAD/SHIFTR/SHIFTL/RESET), op encodings and state encodings SHALL live in a shared package or include file that is also used by registradorX and the bench.
REQ-025 The block SHALL contain no sub-module; the counter and FSM SHALL be inline.
REQ-026 The verification top SHALL instantiate controle_registrador with func driving a registradorX instance on the same clock.

Verification
REQ-027 Reset: reset=1 for 2 cycles -> func=000, busy=0, done=0; all three SHALL stay unchanged while start=0.
REQ-028 LOAD: inX=1011, start=1, op=00 for one cycle -> func=001 for 1 cycle, done pulse 2 cycles after the start edge, outX=1011.
REQ-029 SHIFTR: after loading 1011, op=01, amount=2 -> func=010 for 2 cycles, done at cycle 3, outX=0010; a start pulse mid-command SHALL produce no extra func cycles.
REQ-030 SHIFTL saturation: outX=0011, op=10, amount=7 -> func=011 for exactly 4 cycles, outX=0000, done at cycle 5.
REQ-031 Zero count and CLEAR: op=01, amount=0 -> func stays 000, done next cycle, outX unchanged; then op=11 -> func=100 for 1 cycle, outX=0000.
REQ-032 Abort: reset=1 in the 2nd EXEC cycle of op=10, amount=4 from outX=0001 -> func=000 next cycle, no done pulse, outX=0100.
